dma_char_sequencer: RTL
=======================

Name: dma_char_sequencer

Overview:
- Sequences DMA character transfers from system memory to a serial protocol transmitter (UART/SPI TX front end).
- Holds the 6-bit character counter (car_cont) and uses it to generate memory addresses and detect end of transfer.
- Sits between the CPU-side DMA register file (start, len, src_base) and the memory and protocol ports.
- Exactly one transfer is in flight at any time.

Parameters:
CNT_W, 6, character counter width; maximum transfer length 2^CNT_W-1
ADDR_W, 8, memory address width
DATA_W, 8, character width
TIMEOUT, 15, mem_ack wait limit in cycles (used only with DMA_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle request to begin a transfer; sampled in IDLE only
len  input  CNT_W  number of characters; sampled with start
src_base  input  ADDR_W  first source address; sampled with start
abort  input  1  cancel the transfer in progress
mem_rd  output  1  memory read strobe, held until mem_ack
mem_addr  output  ADDR_W  read address
mem_ack  input  1  read data valid on mem_data this cycle
mem_data  input  DATA_W  read data
tx_valid  output  1  character available on tx_data
tx_data  output  DATA_W  character to transmitter
tx_ready  input  1  transmitter accepts tx_data when high together with tx_valid
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on timeout (DMA_TIMEOUT_EN only; otherwise tied 0)
car_cont  output  CNT_W  characters transferred in the current or last transfer

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_rd=0, mem_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0, car_cont=0.
- States: IDLE, FETCH, SEND, NEXT.
- IDLE:
  - start=1 with len!=0: latch len and src_base, clear car_cont, go to FETCH.
  - start=1 with len=0: pulse done next cycle, clear car_cont, stay IDLE, issue no memory read.
- FETCH:
  - mem_rd=1; mem_addr = src_base + car_cont, truncated modulo 2^ADDR_W (wraps past 0xFF).
  - On mem_ack: register mem_data into tx_data, drop mem_rd, go to SEND.
  - Minimum read latency: mem_ack in the same cycle mem_rd is first high.
- SEND:
  - tx_valid=1; tx_data stays stable until the handshake.
  - On tx_valid&&tx_ready: drop tx_valid, car_cont += 1, go to NEXT.
- NEXT:
  - car_cont==len_latched: pulse done, go to IDLE.
  - Otherwise: go to FETCH.
- Per-character cost with zero-wait memory and transmitter: 3 cycles (FETCH, SEND, NEXT).
- start while busy=1: ignored, with no effect on latched len, src_base or car_cont.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE; mem_rd and tx_valid drop; no done pulse.
  - car_cont holds the count completed so far.
  - A character already handed off (tx handshake done) is counted; a pending one is not.
- abort and tx handshake in the same cycle: the handshake completes (car_cont increments), then the block goes to IDLE.
- abort in IDLE: no effect.
- car_cont never wraps within a transfer, since len ≤ 2^CNT_W-1.
- Reset asserted mid-transfer: immediate return to reset values; no done pulse.

Optional Feature:
DMA_TIMEOUT_EN
- Defined:
  - An internal wait counter clears on entry to FETCH and increments each FETCH cycle without mem_ack.
  - When it reaches TIMEOUT: drop mem_rd, pulse err for one cycle, go to IDLE; car_cont holds its value; no done pulse.
  - mem_ack arriving in the same cycle as the timeout is accepted; no err.
- Undefined:
  - No wait counter is built; FETCH waits indefinitely for mem_ack.
  - err is tied to 0.

Test Plan:
- Basic transfer: len=4, src_base=0x10, memory returns addr^0xA5, zero-wait memory, tx_ready=1.
  - tx_data sequence B5,B4,B7,B6; done pulses once 12 cycles after busy rises; car_cont=4.
- Zero length: len=0, start=1.
  - done pulses next cycle; mem_rd never asserted; busy stays 0; car_cont=0.
- Address wrap and backpressure: src_base=0xFE, len=3, tx_ready low for 5 cycles on each character.
  - mem_addr sequence FE,FF,00; tx_data held stable while tx_valid=1 and tx_ready=0.
- Abort mid-transfer: len=10, abort asserted in SEND of the 4th character with tx_ready=0.
  - Returns to IDLE next edge; car_cont=3; no done; a start pulse while busy earlier is ignored.
- Reset mid-operation: reset driven low asynchronously in FETCH.
  - All outputs return to reset values without waiting for a clk edge.
- Timeout (DMA_TIMEOUT_EN defined, TIMEOUT=15): mem_ack never asserted.
  - err pulses after 15 FETCH cycles; mem_rd drops; car_cont unchanged.
  - Without the macro: mem_rd remains high and err stays 0.

Source files
------------

// File: rtl/dma_char_sequencer.sv
// rtl/dma_char_sequencer.sv - DMA character sequencer: memory fetch to serial TX, one character at a time
// Optional feature macro: DMA_TIMEOUT_EN (mem_ack wait limit with err pulse)
module dma_char_sequencer #(
  parameter int CNT_W   = 6,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  car_cont
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_NEXT  = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_done;

`ifdef DMA_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_err;
`else
  // TIMEOUT only matters when the wait counter is built
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Sequencer: one character per FETCH -> SEND -> NEXT round, abort returns to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_base    <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_done    <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      r_wait    <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (len != '0) begin
              r_len   <= len;
              r_base  <= src_base;
              r_state <= S_FETCH;
`ifdef DMA_TIMEOUT_EN
              r_wait  <= '0;
`endif
            end else begin
              // Zero-length request completes immediately without touching memory
              r_done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (mem_ack) begin
            r_tx_data <= mem_data;
            r_state   <= S_SEND;
`ifdef DMA_TIMEOUT_EN
          end else if (r_wait == WAIT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
`endif
          end
        end
        S_SEND: begin
          // A handshake in the abort cycle still counts as delivered
          if (tx_ready) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= abort ? S_IDLE : S_NEXT;
          end else if (abort) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_cnt == r_len) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_FETCH;
`ifdef DMA_TIMEOUT_EN
            r_wait  <= '0;
`endif
          end
        end
      endcase
    end
  end

  assign mem_rd   = (r_state == S_FETCH);
  assign mem_addr = r_base + ADDR_W'(r_cnt);
  assign tx_valid = (r_state == S_SEND);
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign car_cont = r_cnt;
`ifdef DMA_TIMEOUT_EN
  assign err      = r_err;
`else
  assign err      = 1'b0;
`endif

endmodule
